// File: rtl/etapa_if_param.sv
// Instruction-fetch stage: launches an algorithm from an entry-point table and
// streams words from a 1-cycle-latency synchronous ROM toward decode.
//
//   state | meaning
//   IDLE  | waiting for start; no fetch, instr_valid low
//   RUN   | fetching; pc_q addresses ROM, v_q marks the word now on rom_data
module etapa_if_param #(
    parameter int                      ADDR_W   = 10,
    parameter int                      INSTR_W  = 14,
    parameter int                      N_ALG    = 8,
    parameter int                      SEL_W    = 3,
    parameter logic [N_ALG*ADDR_W-1:0] ALG_BASE = {10'd700, 10'd600, 10'd500, 10'd400,
                                                   10'd300, 10'd200, 10'd100, 10'd0},
    parameter int                      OPC_W    = 4,
    parameter logic [OPC_W-1:0]        HALT_OPC = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [SEL_W-1:0]   alg_sel_i,
    input  logic               abort_i,
    input  logic               stall_i,
    input  logic               br_valid_i,
    input  logic [ADDR_W-1:0]  br_target_i,
    output logic [ADDR_W-1:0]  rom_addr_o,
    output logic               rom_en_o,
    input  logic [INSTR_W-1:0] rom_data_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    output logic               instr_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               sel_err_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                v_q, v_d;
    logic                done_q, done_d;
    logic                sel_err_q, sel_err_d;

    logic [ADDR_W-1:0]   base_sel;
    logic                sel_ok;
    logic [OPC_W-1:0]    opcode;
    logic                halt_hit;

    // Table lookup by loop so an out-of-range alg_sel never indexes past ALG_BASE.
    always_comb begin
        base_sel = '0;
        sel_ok   = 1'b0;
        for (int k = 0; k < N_ALG; k++) begin
            if (int'(alg_sel_i) == k) begin
                base_sel = ALG_BASE[k*ADDR_W +: ADDR_W];
                sel_ok   = 1'b1;
            end
        end
    end

    assign opcode   = rom_data_i[INSTR_W-1 -: OPC_W];
    assign halt_hit = (state_q == RUN) && v_q && !stall_i && (opcode == HALT_OPC);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        v_d        = v_q;
        done_d     = 1'b0;
        sel_err_d  = sel_err_q;

        if (abort_i) begin
            state_d = IDLE;
            v_d     = 1'b0;
        end else if (state_q == IDLE) begin
            v_d = 1'b0;
            if (start_i) begin
                if (sel_ok) begin
                    pc_d      = base_sel;
                    state_d   = RUN;
                    sel_err_d = 1'b0;
                end else begin
                    sel_err_d = 1'b1;
                end
            end
        end else if (halt_hit) begin
            state_d = IDLE;
            v_d     = 1'b0;
            done_d  = 1'b1;
        end else if (!stall_i) begin
            // A redirect drops the word fetched from the old path.
            if (br_valid_i) begin
                pc_d = br_target_i;
                v_d  = 1'b0;
            end else begin
                instr_pc_d = pc_q;
                pc_d       = pc_q + ADDR_W'(1);
                v_d        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            instr_pc_q <= '0;
            v_q        <= 1'b0;
            done_q     <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            v_q        <= v_d;
            done_q     <= done_d;
            sel_err_q  <= sel_err_d;
        end
    end

    // Gating rom_en during stall keeps the ROM output, and so instr, frozen.
    assign rom_addr_o    = pc_q;
    assign rom_en_o      = (state_q == RUN) && !stall_i;
    assign instr_o       = rom_data_i;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = v_q && (state_q == RUN);
    assign busy_o        = (state_q == RUN);
    assign done_o        = done_q;
    assign sel_err_o     = sel_err_q;

endmodule

// File: tb/tb_etapa_if_param.sv
// Bench for etapa_if_param: ROM model plus a queue of expected fetched PCs,
// popped whenever the stage delivers a word (valid and not stalled).
module tb_etapa_if_param;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 14;
    localparam int SEL_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_i, abort_i, stall_i, br_valid_i;
    logic [SEL_W-1:0]   alg_sel_i;
    logic [ADDR_W-1:0]  br_target_i;
    logic [ADDR_W-1:0]  rom_addr_o, instr_pc_o;
    logic               rom_en_o;
    logic [INSTR_W-1:0] rom_data_i = '0;
    logic [INSTR_W-1:0] instr_o;
    logic               instr_valid_o, busy_o, done_o, sel_err_o;

    logic [INSTR_W-1:0] rom [1024];
    int                 checks   = 0;
    int                 failures = 0;
    int unsigned        exp_q[$];
    int unsigned        mon_e;

    etapa_if_param #(.SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_i(start_i), .alg_sel_i(alg_sel_i), .abort_i(abort_i),
        .stall_i(stall_i), .br_valid_i(br_valid_i), .br_target_i(br_target_i),
        .rom_addr_o(rom_addr_o), .rom_en_o(rom_en_o), .rom_data_i(rom_data_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o),
        .busy_o(busy_o), .done_o(done_o), .sel_err_o(sel_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en_o) rom_data_i <= rom[rom_addr_o];

    function automatic logic [INSTR_W-1:0] word_at(int unsigned pc);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(pc);
        return (pc == 710) ? {4'hF, a} : {4'h1, a};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(int unsigned lo, int unsigned hi);
        for (int unsigned p = lo; p <= hi; p++) exp_q.push_back(p);
    endtask

    always @(negedge clk) begin
        if (rst_n && instr_valid_o && !stall_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_instr", 32'(instr_pc_o), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("instr_pc", 32'(instr_pc_o), mon_e);
                check("instr", 32'(instr_o), 32'(word_at(mon_e)));
                check("busy_with_valid", 32'(busy_o), 1);
            end
        end
    end

    initial begin
        for (int a = 0; a < 1024; a++) rom[a] = word_at(a);
        rst_n = 1'b0; start_i = 0; abort_i = 0; stall_i = 0; br_valid_i = 0;
        alg_sel_i = '0; br_target_i = '0;
        repeat (2) step();
        check("rst_busy", 32'(busy_o), 0);
        check("rst_valid", 32'(instr_valid_o), 0);
        check("rst_rom_addr", 32'(rom_addr_o), 0);
        check("rst_rom_en", 32'(rom_en_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_sel_err", 32'(sel_err_o), 0);
        rst_n = 1'b1;
        step();

        // launch alg 2, stall at 205, branch at 207 to 50, then wrap through 1023
        push_range(200, 207);
        exp_q.push_back(50); exp_q.push_back(51);
        exp_q.push_back(1023); exp_q.push_back(0);
        start_i = 1; alg_sel_i = 2;
        step();
        start_i = 0;
        check("start_rom_addr", 32'(rom_addr_o), 200);
        check("start_busy", 32'(busy_o), 1);
        check("start_valid", 32'(instr_valid_o), 0);
        check("start_rom_en", 32'(rom_en_o), 1);
        repeat (6) step();
        stall_i = 1;
        #1;
        check("stall_rom_en", 32'(rom_en_o), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", 32'(instr_pc_o), 205);
            check("stall_valid", 32'(instr_valid_o), 1);
            check("stall_instr", 32'(instr_o), 32'(word_at(205)));
            check("stall_rom_en", 32'(rom_en_o), 0);
        end
        stall_i = 0;
        step();
        step();
        br_valid_i = 1; br_target_i = 50;
        step();
        br_valid_i = 0;
        check("br_flush_valid", 32'(instr_valid_o), 0);
        check("br_rom_addr", 32'(rom_addr_o), 50);
        step();
        step();
        br_valid_i = 1; br_target_i = 1023;
        step();
        br_valid_i = 0;
        step();
        step();
        abort_i = 1;
        step();
        abort_i = 0;
        check("abort_busy", 32'(busy_o), 0);
        check("abort_valid", 32'(instr_valid_o), 0);
        check("abort_done", 32'(done_o), 0);
        check("abort_pc_hold", 32'(rom_addr_o), 1);
        step();
        check("abort_done_later", 32'(done_o), 0);

        // alg 7 runs into the HALT word at 710
        push_range(700, 710);
        start_i = 1; alg_sel_i = 7;
        step();
        start_i = 0;
        check("alg7_rom_addr", 32'(rom_addr_o), 700);
        repeat (11) step();
        check("pre_halt_done", 32'(done_o), 0);
        step();
        check("halt_done", 32'(done_o), 1);
        check("halt_busy", 32'(busy_o), 0);
        check("halt_valid", 32'(instr_valid_o), 0);
        step();
        check("halt_done_pulse", 32'(done_o), 0);

        // out-of-range select, then a valid start clears the error
        start_i = 1; alg_sel_i = 8;
        step();
        check("selerr_flag", 32'(sel_err_o), 1);
        check("selerr_busy", 32'(busy_o), 0);
        alg_sel_i = 1;
        step();
        start_i = 0;
        check("selerr_clear", 32'(sel_err_o), 0);
        check("alg1_busy", 32'(busy_o), 1);
        check("alg1_rom_addr", 32'(rom_addr_o), 100);
        push_range(100, 101);
        step();
        step();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy_o), 0);
        check("async_rst_valid", 32'(instr_valid_o), 0);
        check("async_rst_pc", 32'(rom_addr_o), 0);
        check("async_rst_instr_pc", 32'(instr_pc_o), 0);
        check("async_rst_rom_en", 32'(rom_en_o), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("post_rst_busy", 32'(busy_o), 0);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
